// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH  = 32;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
  localparam int unsigned DEF_CNT_WIDTH      = 16;

  // Register r0 is hard-wired to zero, so writes to it never create a hazard.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    ST_RUN           = 1'b0,
    ST_REDIRECT_PEND = 1'b1
  } hazard_state_e;

  // Stall/flush/redirect controls driven to the pipe registers.
  typedef struct packed {
    logic pc_stall;
    logic redirect;
    logic stall_if_dec;
    logic flush_if_dec;
    logic stall_dec_ex;
    logic flush_dec_ex;
    logic stall_ex_mem;
    logic flush_mem_wb;
  } hazard_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard sequencer: hazard sources in, pipe controls out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) ();

  logic                      dec_uses_rs;
  logic [REG_ADDR_WIDTH-1:0] dec_rs_addr;
  logic                      dec_uses_rt;
  logic [REG_ADDR_WIDTH-1:0] dec_rt_addr;
  logic                      ex_load;
  logic                      ex_writes_back;
  logic [REG_ADDR_WIDTH-1:0] ex_write_addr;
  logic                      ex_is_branch;
  logic                      ex_prediction;
  logic                      ex_taken;
  logic [ADDRESS_WIDTH-1:0]  ex_correct_pc;
  logic                      dmem_busy;
  logic                      imem_busy;

  logic                      pc_stall;
  logic                      redirect;
  logic [ADDRESS_WIDTH-1:0]  redirect_pc;
  logic                      stall_if_dec;
  logic                      flush_if_dec;
  logic                      stall_dec_ex;
  logic                      flush_dec_ex;
  logic                      stall_ex_mem;
  logic                      flush_mem_wb;
  logic [CNT_WIDTH-1:0]      stall_count;
  logic [CNT_WIDTH-1:0]      mispredict_count;

  // Pipeline side: supplies hazard sources, consumes controls.
  modport master (
    output dec_uses_rs, dec_rs_addr, dec_uses_rt, dec_rt_addr,
           ex_load, ex_writes_back, ex_write_addr,
           ex_is_branch, ex_prediction, ex_taken, ex_correct_pc,
           dmem_busy, imem_busy,
    input  pc_stall, redirect, redirect_pc,
           stall_if_dec, flush_if_dec, stall_dec_ex, flush_dec_ex,
           stall_ex_mem, flush_mem_wb, stall_count, mispredict_count
  );

  // Sequencer side.
  modport slave (
    input  dec_uses_rs, dec_rs_addr, dec_uses_rt, dec_rt_addr,
           ex_load, ex_writes_back, ex_write_addr,
           ex_is_branch, ex_prediction, ex_taken, ex_correct_pc,
           dmem_busy, imem_busy,
    output pc_stall, redirect, redirect_pc,
           stall_if_dec, flush_if_dec, stall_dec_ex, flush_dec_ex,
           stall_ex_mem, flush_mem_wb, stall_count, mispredict_count
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Count enabled events until saturated.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic         i_Clk,
  input  logic         i_Reset_n,
  pipe_hazard_ctrl_if.slave bus
);

  hazard_state_e            state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pend_pc, pend_pc_nxt;
  logic [ADDRESS_WIDTH-1:0] redirect_pc;
  hazard_ctrl_t             ctrl;
  logic                     load_use;
  logic                     mispredict;
  logic                     stall_inc;
  logic                     mispredict_inc;
  logic                     rs_hit;
  logic                     rt_hit;

  // Hazard detection from DEC/EX operands and branch resolution.
  always_comb begin
    rs_hit     = bus.dec_uses_rs && (bus.dec_rs_addr == bus.ex_write_addr);
    rt_hit     = bus.dec_uses_rt && (bus.dec_rt_addr == bus.ex_write_addr);
    load_use   = bus.ex_load && bus.ex_writes_back &&
                 (bus.ex_write_addr != REG_ADDR_WIDTH'(REG_ZERO)) && (rs_hit || rt_hit);
    mispredict = bus.ex_is_branch && (bus.ex_taken != bus.ex_prediction);
  end

  // Next state, latched target and same-cycle pipe controls.
  always_comb begin
    state_nxt      = state;
    pend_pc_nxt    = pend_pc;
    redirect_pc    = '0;
    ctrl           = '0;
    stall_inc      = 1'b0;
    mispredict_inc = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.dmem_busy) begin
          // Freeze everything up to EX; the branch, if any, waits in EX.
          ctrl.pc_stall     = 1'b1;
          ctrl.stall_if_dec = 1'b1;
          ctrl.stall_dec_ex = 1'b1;
          ctrl.stall_ex_mem = 1'b1;
          ctrl.flush_mem_wb = 1'b1;
          stall_inc         = 1'b1;
        end else if (mispredict) begin
          ctrl.redirect     = 1'b1;
          redirect_pc       = bus.ex_correct_pc;
          ctrl.flush_if_dec = 1'b1;
          ctrl.flush_dec_ex = 1'b1;
          mispredict_inc    = 1'b1;
          if (bus.imem_busy) begin
            state_nxt   = ST_REDIRECT_PEND;
            pend_pc_nxt = bus.ex_correct_pc;
          end
        end else if (load_use) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.stall_if_dec = 1'b1;
          ctrl.flush_dec_ex = 1'b1;
          stall_inc         = 1'b1;
        end else if (bus.imem_busy) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.flush_if_dec = 1'b1;
        end
      end
      ST_REDIRECT_PEND: begin
        ctrl.redirect     = 1'b1;
        redirect_pc       = pend_pc;
        ctrl.flush_if_dec = 1'b1;
        if (bus.dmem_busy) begin
          // if_dec is being flushed, so it is not stalled here.
          ctrl.pc_stall     = 1'b1;
          ctrl.stall_dec_ex = 1'b1;
          ctrl.stall_ex_mem = 1'b1;
          ctrl.flush_mem_wb = 1'b1;
        end
        if (!bus.imem_busy) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // FSM state and pending redirect target.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state   <= ST_RUN;
      pend_pc <= '0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  // Controls are forced low while reset is held.
  always_comb begin
    bus.pc_stall     = i_Reset_n && ctrl.pc_stall;
    bus.redirect     = i_Reset_n && ctrl.redirect;
    bus.redirect_pc  = i_Reset_n ? redirect_pc : '0;
    bus.stall_if_dec = i_Reset_n && ctrl.stall_if_dec;
    bus.flush_if_dec = i_Reset_n && ctrl.flush_if_dec;
    bus.stall_dec_ex = i_Reset_n && ctrl.stall_dec_ex;
    bus.flush_dec_ex = i_Reset_n && ctrl.flush_dec_ex;
    bus.stall_ex_mem = i_Reset_n && ctrl.stall_ex_mem;
    bus.flush_mem_wb = i_Reset_n && ctrl.flush_mem_wb;
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .inc       (stall_inc),
    .count     (bus.stall_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .inc       (mispredict_inc),
    .count     (bus.mispredict_count)
  );

endmodule
